// File: rtl/uart_pkg.sv
// Shared constants and types for the UART transmit path.
//   CLK_FRE / UART_FRE : system clock (MHz) and line rate (baud)
//   TIMEOUT_CYC_DEF    : default idle timeout for the tx arbiter (1 s of sys_clk)
//   MAX_REQ / GRANT_W  : largest supported requester count and width of grant_id
//   arb_state_e        : tx arbiter state encoding
package uart_pkg;

  localparam int CLK_FRE         = 27;               // MHz
  localparam int UART_FRE        = 115200;           // baud
  localparam int TIMEOUT_CYC_DEF = CLK_FRE * 1_000_000;

  localparam int MAX_REQ = 8;
  localparam int GRANT_W = 3;

  typedef enum logic {
    ARB   = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bundle between the requesters, the tx arbiter and uart_tx.
//   req_data/req_valid/req_last : per-requester byte, valid and end-of-packet
//   req_ready                   : per-requester byte accepted
//   tx_data/tx_data_valid       : byte offered to uart_tx
//   tx_data_ready               : uart_tx can take the byte
// master is the arbiter's view; slave is the view of the logic around it
// (requesters plus uart_tx).
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_data_valid;
  logic                 tx_data_ready;

  modport master (
    input  req_data, req_valid, req_last, tx_data_ready,
    output req_ready, tx_data, tx_data_valid
  );

  modport slave (
    output req_data, req_valid, req_last, tx_data_ready,
    input  req_ready, tx_data, tx_data_valid
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority picker.
//   req     : request vector
//   ptr     : most recent grantee; the search starts at ptr+1 (mod NUM_REQ)
//   gnt     : one-hot winner
//   idx     : encoded winner, zero-extended to GRANT_W
//   any_req : at least one request is present
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GRANT_W-1:0] ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [GRANT_W-1:0] idx,
  output logic               any_req
);

  // Each requester's distance from ptr+1 in search order; the requesting
  // one with the smallest distance wins.
  always_comb begin
    int d;
    int best_d;
    // NOTE: every output and temporary gets a default before any branch, so
    // no path leaves a value unassigned and no latch is inferred.
    gnt     = '0;
    idx     = '0;
    any_req = 1'b0;
    best_d  = NUM_REQ;
    d       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      d = i - int'(ptr) - 1;
      if (d < 0) d = d + NUM_REQ;
      if (req[i] && d < best_d) begin
        best_d  = d;
        idx     = GRANT_W'(i);
        any_req = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt[i] = any_req && (idx == GRANT_W'(i));
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NUM_REQ byte-stream requesters, round-robin at
// packet granularity, with an idle timeout that reclaims a stalled grant.
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   bus (master)       : requester byte streams in, uart_tx handshake out
//   grant_id           : index of the granted requester (zero-extended)
//   busy               : a grant is held
//   timeout_evt        : one-cycle pulse when the timeout revokes a grant
// While granted, the granted stream is passed straight through to uart_tx
// with no added latency; each packet costs one arbitration cycle.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int CNT_W       = 32
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  uart_tx_arbiter_if.master  bus,
  output logic [GRANT_W-1:0] grant_id,
  output logic               busy,
  output logic               timeout_evt
);

  localparam bit             TO_EN   = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] TO_LAST =
    (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);

  arb_state_e         state;
  logic [NUM_REQ-1:0] grant_oh;   // one-hot copy of grant_id, zero outside GRANT
  logic [GRANT_W-1:0] rr_ptr;
  logic [CNT_W-1:0]   idle_cnt;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [GRANT_W-1:0] pick_idx;
  logic               any_req;

  logic [7:0]         g_data;
  logic               g_valid;
  logic               g_last;
  logic               xfer;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req     (bus.req_valid),
    .ptr     (rr_ptr),
    .gnt     (pick_gnt),
    .idx     (pick_idx),
    .any_req (any_req)
  );

  // AND-OR select of the granted stream; grant_oh is all-zero in ARB, which
  // keeps the uart_tx side quiet there without extra gating.
  always_comb begin
    g_data  = '0;
    g_valid = 1'b0;
    g_last  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_oh[i]) begin
        g_data  = bus.req_data[i*8 +: 8];
        g_valid = bus.req_valid[i];
        g_last  = bus.req_last[i];
      end
    end
  end

  assign bus.tx_data       = g_data;
  assign bus.tx_data_valid = g_valid;
  assign bus.req_ready     = grant_oh & {NUM_REQ{bus.tx_data_ready}};
  assign xfer              = g_valid & bus.tx_data_ready;

  // NOTE: non-blocking assignments throughout, so every decision in this
  // block is made on the values registered before the edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= ARB;
      grant_id    <= '0;
      grant_oh    <= '0;
      busy        <= 1'b0;
      timeout_evt <= 1'b0;
      idle_cnt    <= '0;
      rr_ptr      <= GRANT_W'(NUM_REQ - 1);
    end else begin
      timeout_evt <= 1'b0;
      case (state)
        ARB: begin
          if (any_req) begin
            state    <= GRANT;
            grant_id <= pick_idx;
            grant_oh <= pick_gnt;
            busy     <= 1'b1;
            idle_cnt <= '0;
          end
        end
        GRANT: begin
          if (xfer) begin
            idle_cnt <= '0;
            if (g_last) begin
              state    <= ARB;
              rr_ptr   <= grant_id;
              grant_oh <= '0;
              busy     <= 1'b0;
            end
          end else if (TO_EN && !g_valid) begin
            // Only counts while nothing is offered, so a byte already shown
            // to uart_tx is never withdrawn by the timeout.
            if (idle_cnt == TO_LAST) begin
              timeout_evt <= 1'b1;
              state       <= ARB;
              rr_ptr      <= grant_id;
              grant_oh    <= '0;
              busy        <= 1'b0;
              idle_cnt    <= '0;
            end else begin
              idle_cnt <= idle_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule
